// File: rtl/encoder83_pkg.sv
// encoder83_pkg
//   Shared definitions for the 8-to-3 active-low key-scan encoder:
//   line count, code width, the "no line active" vector, the FSM state
//   type and the priority-encode helper.
//   Optional build macro used by this block: ENCODER83_SYNC_EN (see
//   encoder83_debounce).
package encoder83_pkg;

  localparam int             LINES_N  = 8;
  localparam int             SEL_W    = 3;
  localparam logic [7:0]     IDLE_VEC = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VALID    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  // Index of the highest-numbered zero bit; 0 when no bit is low.
  // Ascending scan so the last (highest) hit wins.
  function automatic logic [SEL_W-1:0] pri_code(input logic [LINES_N-1:0] vec_n);
    pri_code = '0;
    for (int i = 0; i < LINES_N; i++) begin
      if (!vec_n[i]) pri_code = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/encoder83_debounce.sv
// encoder83_debounce
//   Samples the active-low request lines and debounces them: the stable
//   vector only takes a new value after the sampled lines differ from it
//   and stay constant for DB_CYCLES consecutive cycles.
//   Build option: with ENCODER83_SYNC_EN defined a two-flop synchroniser
//   (reset to all-ones) sits ahead of the sample register, adding two
//   cycles of latency; otherwise i_y_n must already be synchronous.
// Ports
//   i_clk       in   1  system clock, rising edge
//   i_rst_n     in   1  asynchronous active-low reset
//   i_y_n       in   8  raw request lines, active low
//   o_stable_n  out  8  debounced request vector, active low
module encoder83_debounce
  import encoder83_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [LINES_N-1:0] i_y_n,
  output logic [LINES_N-1:0] o_stable_n
);

  localparam int               CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [LINES_N-1:0] raw_p0;
  logic [LINES_N-1:0] sample_p1;
  logic [LINES_N-1:0] stable_p2;
  logic [CNT_W-1:0]   cnt;

`ifdef ENCODER83_SYNC_EN
  logic [LINES_N-1:0] sync_a;
  logic [LINES_N-1:0] sync_b;

  // Stage: two-flop synchroniser for asynchronous key lines
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_a <= IDLE_VEC;
      sync_b <= IDLE_VEC;
    end else begin
      sync_a <= i_y_n;
      sync_b <= sync_a;
    end
  end

  assign raw_p0 = sync_b;
`else
  assign raw_p0 = i_y_n;
`endif

  // Stage: sample register and debounce counter / stable vector.
  // "Held constant" means the value arriving at the sample register
  // matches the one already in it, so the count starts on the first
  // cycle the new value sits in the sample register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sample_p1 <= IDLE_VEC;
      stable_p2 <= IDLE_VEC;
      cnt       <= '0;
    end else begin
      sample_p1 <= raw_p0;
      if ((sample_p1 == stable_p2) || (raw_p0 != sample_p1)) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable_p2 <= sample_p1;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_stable_n = stable_p2;

endmodule

// File: rtl/encoder83_keyscan.sv
// encoder83_keyscan
//   Debounces 8 active-low request lines and priority-encodes them to a
//   3-bit index (bit 7 highest priority), emitting exactly one
//   valid/ready event per press. Further presses are ignored until all
//   lines are released.
//   Build option: ENCODER83_SYNC_EN adds an input synchroniser (+2 cycles
//   latency) inside encoder83_debounce.
// Parameters
//   DB_CYCLES  consecutive identical samples needed to accept a change (>=1)
// Ports
//   i_clk     in   1  system clock, rising edge
//   i_rst_n   in   1  asynchronous active-low reset
//   i_y_n     in   8  request lines, active low; 8'hFF = none active
//   i_ready   in   1  consumer accepts the event when high with o_valid
//   o_sel     out  3  index of highest-priority active line at capture
//   o_valid   out  1  event pending, held until accepted
//   o_active  out  1  debounced vector has at least one line active
module encoder83_keyscan
  import encoder83_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [LINES_N-1:0] i_y_n,
  input  logic               i_ready,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_valid,
  output logic               o_active
);

  logic [LINES_N-1:0] stable_n;
  logic               pressed;
  state_t             state;
  state_t             state_nx;
  logic [SEL_W-1:0]   sel_nx;
  logic               valid_nx;

  encoder83_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_y_n      (i_y_n),
    .o_stable_n (stable_n)
  );

  assign pressed  = (stable_n != IDLE_VEC);
  // Driven straight from the stable register, so it moves on the same
  // edge as the debounced vector.
  assign o_active = pressed;

  // Stage: event FSM and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_sel   <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_nx;
      o_sel   <= sel_nx;
      o_valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = o_sel;
    valid_nx = o_valid;
    case (state)
      IDLE: begin
        if (pressed) begin
          sel_nx   = pri_code(stable_n);
          valid_nx = 1'b1;
          state_nx = VALID;
        end
      end
      VALID: begin
        // o_sel is frozen here regardless of what the lines do.
        if (o_valid && i_ready) begin
          valid_nx = 1'b0;
          state_nx = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!pressed) state_nx = IDLE;
      end
      default: begin
        valid_nx = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_encoder83_keyscan.sv
module tb_encoder83_keyscan;

  localparam int DB = 4;
`ifdef ENCODER83_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif
  // cycles from an input change to o_valid rising
  localparam int LAT = 1 + DB + 1 + SYNC_STAGES;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] y_n   = 8'hFF;
  logic [2:0] sel;
  logic       valid;
  logic       active;

  int total = 0;
  int bad   = 0;

  encoder83_keyscan #(.DB_CYCLES(DB)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_y_n    (y_n),
    .i_ready  (ready),
    .o_sel    (sel),
    .o_valid  (valid),
    .o_active (active)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- behavioural reference model ----------------
  // Debounced value = a sampled value that has appeared in DB+1
  // consecutive samples and differs from the current debounced value.
  logic [7:0] m_sync [2];
  logic [7:0] m_last;
  logic [7:0] m_stable;
  int         m_run;
  bit         m_valid;
  bit         m_wait;
  logic [2:0] m_sel;

  function automatic logic [2:0] top_zero(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (!v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_rst();
    m_sync[0] = 8'hFF;
    m_sync[1] = 8'hFF;
    m_last    = 8'hFF;
    m_stable  = 8'hFF;
    m_run     = 1;
    m_valid   = 0;
    m_wait    = 0;
    m_sel     = 3'd0;
  endtask

  task automatic model_edge();
    logic [7:0] samp;
    if (!rst_n) begin
      model_rst();
      return;
    end
    if (SYNC_STAGES == 2) begin
      samp      = m_sync[1];
      m_sync[1] = m_sync[0];
      m_sync[0] = y_n;
    end else begin
      samp = y_n;
    end
    // event logic sees the debounced value from before this edge
    if (m_valid) begin
      if (ready) begin
        m_valid = 0;
        m_wait  = 1;
      end
    end else if (m_wait) begin
      if (m_stable == 8'hFF) m_wait = 0;
    end else if (m_stable != 8'hFF) begin
      m_valid = 1;
      m_sel   = top_zero(m_stable);
    end
    if (samp == m_last) m_run++;
    else m_run = 1;
    m_last = samp;
    if (m_run > DB && samp != m_stable) m_stable = samp;
  endtask

  function automatic logic [4:0] m_out();
    return {(m_stable != 8'hFF), m_valid, m_sel};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3 rst_n = 1'b0;
    model_rst();
    #1;
    total++; if (sel !== 3'd0)  begin bad++; $display("FAIL reset_sel got=%0d want=0", sel); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", active); end
    tick();
    #3 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if ({active, valid, sel} !== 5'd0) begin
        bad++; $display("FAIL reset_idle cyc=%0d got=%b want=00000", c, {active, valid, sel});
      end
    end
  endtask

  task automatic test_press(input logic [7:0] pat, input logic [2:0] exp_sel, input string name);
    int first = -1;
    int nvalid = 0;
    ready = 1'b1;
    y_n   = pat;
    for (int c = 1; c <= LAT + 25; c++) begin
      tick();
      total++;
      if ({active, valid, sel} !== m_out()) begin
        bad++; $display("FAIL %s_model cyc=%0d got=%b want=%b", name, c, {active, valid, sel}, m_out());
      end
      if (valid) begin
        nvalid++;
        if (first < 0) first = c;
      end
    end
    total++; if (first != LAT) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, first, LAT); end
    total++; if (nvalid != 1)  begin bad++; $display("FAIL %s_count got=%0d want=1", name, nvalid); end
    total++; if (sel !== exp_sel) begin bad++; $display("FAIL %s_sel got=%0d want=%0d", name, sel, exp_sel); end
    y_n = 8'hFF;
    drain(LAT + 3);
    total++; if (active !== 1'b0) begin bad++; $display("FAIL %s_release got=%b want=0", name, active); end
  endtask

  task automatic test_bounce();
    bit seen = 0;
    int first = -1;
    int nvalid = 0;
    ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      y_n = (((c / 2) % 2) == 0) ? 8'hFE : 8'hFF;
      tick();
      total++;
      if ({active, valid, sel} !== m_out()) begin
        bad++; $display("FAIL bounce_model cyc=%0d got=%b want=%b", c, {active, valid, sel}, m_out());
      end
      if (valid) seen = 1;
    end
    total++; if (seen) begin bad++; $display("FAIL bounce_quiet got=valid want=no_valid"); end
    y_n = 8'hFE;
    for (int c = 1; c <= LAT + 10; c++) begin
      tick();
      if (valid) begin
        nvalid++;
        if (first < 0) first = c;
      end
    end
    total++; if (first != LAT) begin bad++; $display("FAIL bounce_latency got=%0d want=%0d", first, LAT); end
    total++; if (nvalid != 1) begin bad++; $display("FAIL bounce_count got=%0d want=1", nvalid); end
    total++; if (sel !== 3'd0) begin bad++; $display("FAIL bounce_sel got=%0d want=0", sel); end
    y_n = 8'hFF;
    drain(LAT + 3);
  endtask

  task automatic test_hold_ready_low();
    int guard = 0;
    ready = 1'b0;
    y_n   = 8'hDF;
    while (!valid && guard < 30) begin tick(); guard++; end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL hold_event got=%b want=1", valid); end
    y_n = 8'hFF;
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (valid !== 1'b1 || sel !== 3'd5 || {active, valid, sel} !== m_out()) begin
        bad++; $display("FAIL hold_pending cyc=%0d got=%b want=%b", c, {active, valid, sel}, m_out());
      end
    end
    ready = 1'b1;
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL hold_accept got=%b want=0", valid); end
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (valid !== 1'b0) begin bad++; $display("FAIL hold_second cyc=%0d got=%b want=0", c, valid); end
    end
    y_n = 8'hF7;
    guard = 0;
    while (!valid && guard < 30) begin tick(); guard++; end
    total++; if (valid !== 1'b1 || sel !== 3'd3) begin
      bad++; $display("FAIL hold_next got=%b/%0d want=1/3", valid, sel);
    end
    y_n = 8'hFF;
    drain(LAT + 3);
  endtask

  task automatic test_reset_in_valid();
    int guard = 0;
    int first = -1;
    ready = 1'b0;
    y_n   = 8'hEF;
    while (!valid && guard < 30) begin tick(); guard++; end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL rstv_event got=%b want=1", valid); end
    #3 rst_n = 1'b0;
    model_rst();
    #1;
    total++; if ({active, valid, sel} !== 5'd0) begin
      bad++; $display("FAIL rstv_async got=%b want=00000", {active, valid, sel});
    end
    tick();
    #3 rst_n = 1'b1;
    for (int c = 1; c <= LAT + 6; c++) begin
      tick();
      total++;
      if ({active, valid, sel} !== m_out()) begin
        bad++; $display("FAIL rstv_model cyc=%0d got=%b want=%b", c, {active, valid, sel}, m_out());
      end
      if (valid && first < 0) first = c;
    end
    total++; if (first != LAT || sel !== 3'd4) begin
      bad++; $display("FAIL rstv_fresh got=%0d/%0d want=%0d/4", first, sel, LAT);
    end
    ready = 1'b1;
    y_n   = 8'hFF;
    drain(LAT + 3);
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        y_n  = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
        hold = $urandom_range(1, 12);
      end
      hold--;
      ready = 1'($urandom_range(0, 1));
      tick();
      total++;
      if ({active, valid, sel} !== m_out()) begin
        bad++; $display("FAIL random_model cyc=%0d got=%b want=%b", c, {active, valid, sel}, m_out());
      end
    end
    ready = 1'b1;
    y_n   = 8'hFF;
    drain(LAT + 6);
  endtask

  initial begin
    model_rst();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({active, valid, sel} !== 5'd0) begin
      bad++; $display("FAIL power_on got=%b want=00000", {active, valid, sel});
    end
    rst_n = 1'b1;
    test_reset();
    test_press(8'b1111_1011, 3'd2, "press_b2");
    test_press(8'b0111_1110, 3'd7, "press_b7");
    test_bounce();
    test_hold_ready_low();
    test_reset_in_valid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
